// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch (IF) and load/store (D) ports
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break instead of D-over-IF priority)

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Counter is sized for the legal latency range 1..15.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t            state;
    owner_t            owner;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              win_if;
    logic              win_d;
    logic              idle_ok;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t            last_owner;

    // Tie goes to whichever port did not win the previous grant; single requests win outright.
    always_comb begin
        win_if = 1'b0;
        win_d  = 1'b0;
        if (if_req && d_req) begin
            if (last_owner == OWN_IF) begin
                win_d = 1'b1;
            end else begin
                win_if = 1'b1;
            end
        end else begin
            win_if = if_req;
            win_d  = d_req;
        end
    end

    // Remember the owner of every grant so the next tie flips; reset value makes the first tie go to D.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_IF;
        end else if (d_gnt) begin
            last_owner <= OWN_D;
        end else if (if_gnt) begin
            last_owner <= OWN_IF;
        end
    end
`else
    // Fixed priority: a load/store always beats a fetch.
    always_comb begin
        win_d  = d_req;
        win_if = if_req && !d_req;
    end
`endif

    // Grants only exist in IDLE and never in a reset cycle, so an accepted request is never lost.
    assign idle_ok = (state == ST_IDLE) && !reset;
    assign d_gnt   = idle_ok && win_d;
    assign if_gnt  = idle_ok && win_if;

    // Memory bus comes straight from the request latched at grant time.
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_we    = (state == ST_ACCESS) && (cnt == 4'd0) && lat_we && !reset;

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // Access sequencer: latch on grant, hold the address MEM_LAT cycles, sample, respond, return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= OWN_IF;
            cnt         <= 4'd0;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_gnt) begin
                        owner     <= OWN_D;
                        lat_addr  <= d_addr;
                        lat_we    <= d_we;
                        lat_wdata <= d_wdata;
                        cnt       <= CNT_INIT;
                        state     <= ST_ACCESS;
                    end else if (if_gnt) begin
                        owner     <= OWN_IF;
                        lat_addr  <= if_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= '0;
                        cnt       <= CNT_INIT;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (owner == OWN_D) begin
                            d_rdata_q  <= mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata;
                            if_rvalid_q <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (instance 0: MEM_LAT=1, instance 1: MEM_LAT=3)

module tb_mem_port_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_init;
    logic [1:0]       if_req;
    logic [1:0][31:0] if_addr;
    logic [1:0]       if_gnt;
    logic [1:0]       if_rvalid;
    logic [1:0][31:0] if_rdata;
    logic [1:0]       d_req;
    logic [1:0]       d_we;
    logic [1:0][31:0] d_addr;
    logic [1:0][31:0] d_wdata;
    logic [1:0]       d_gnt;
    logic [1:0]       d_rvalid;
    logic [1:0][31:0] d_rdata;
    logic [1:0][31:0] mem_addr;
    logic [1:0]       mem_we;
    logic [1:0][31:0] mem_wdata;
    logic [1:0][31:0] mem_rdata;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    logic [31:0] ref_mem   [2][64];
    logic [31:0] exp_if_rd [2];
    logic [31:0] exp_d_rd  [2];
    bit          d_known   [2];
    int          last_win  [2];

    int n_chk;
    int n_fail;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
        .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
        .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    function automatic logic [31:0] init_val(int i);
        return (i == 5) ? 32'h0081_0003 : (32'hA500_0000 + 32'(i));
    endfunction

    // Memory models: combinational read, write on the clock edge while mem_we is high
    assign mem_rdata[0] = mem0[mem_addr[0][5:0]];
    assign mem_rdata[1] = mem1[mem_addr[1][5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= init_val(i);
                mem1[i] <= init_val(i);
            end
        end else begin
            if (mem_we[0]) mem0[mem_addr[0][5:0]] <= mem_wdata[0];
            if (mem_we[1]) mem1[mem_addr[1][5:0]] <= mem_wdata[1];
        end
    end

    function automatic logic [31:0] mem_at(int k, int i);
        return (k == 0) ? mem0[i] : mem1[i];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Who should win: 1 = D, 0 = IF
    function automatic int pick(int k, bit ir, bit dr);
        if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last_win[k] == 1) ? 0 : 1;
`else
            return (k >= 0) ? 1 : 1;
`endif
        end
        return dr ? 1 : 0;
    endfunction

    task automatic model_reset;
        for (int k = 0; k < 2; k++) begin
            exp_if_rd[k] = '0;
            exp_d_rd[k]  = '0;
            d_known[k]   = 1'b1;
            last_win[k]  = 0;
        end
    endtask

    task automatic chk_zero(input int k);
        chk1("rst_if_gnt", if_gnt[k], 1'b0);
        chk1("rst_d_gnt", d_gnt[k], 1'b0);
        chk1("rst_if_rvalid", if_rvalid[k], 1'b0);
        chk1("rst_d_rvalid", d_rvalid[k], 1'b0);
        chk1("rst_mem_we", mem_we[k], 1'b0);
        chk("rst_if_rdata", if_rdata[k], 32'h0);
        chk("rst_d_rdata", d_rdata[k], 32'h0);
        chk("rst_mem_addr", mem_addr[k], 32'h0);
        chk("rst_mem_wdata", mem_wdata[k], 32'h0);
    endtask

    task automatic do_reset;
        if_req = '0;
        d_req  = '0;
        reset  = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        model_reset;
        #1;
        chk_zero(0);
        chk_zero(1);
        tick;
    endtask

    // One granted access checked end to end: grant now, MEM_LAT bus cycles, one response cycle.
    task automatic serve(input int k, input bit keep, input bit late_if, output int w);
        logic [31:0] ea;
        logic [31:0] ewd;
        bit          ewe;
        int          lat;
        int          idx;
        lat = (k == 0) ? 1 : 3;
        w = pick(k, if_req[k], d_req[k]);
        #1;
        chk1("if_gnt", if_gnt[k], w == 0);
        chk1("d_gnt", d_gnt[k], w == 1);
        chk1("idle_if_rvalid", if_rvalid[k], 1'b0);
        chk1("idle_d_rvalid", d_rvalid[k], 1'b0);
        if (w == 1) begin
            ea  = d_addr[k];
            ewe = d_we[k];
            ewd = d_wdata[k];
        end else begin
            ea  = if_addr[k];
            ewe = 1'b0;
            ewd = '0;
        end
        idx = int'(ea[5:0]);
        last_win[k] = w;
        tick;
        if (!keep) begin
            if (w == 1) d_req[k] = 1'b0;
            else        if_req[k] = 1'b0;
        end
        if (late_if) if_req[k] = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            #1;
            chk("acc_mem_addr", mem_addr[k], ea);
            chk1("acc_mem_we", mem_we[k], ewe && (c == lat));
            if (ewe) chk("acc_mem_wdata", mem_wdata[k], ewd);
            chk1("acc_if_gnt", if_gnt[k], 1'b0);
            chk1("acc_d_gnt", d_gnt[k], 1'b0);
            chk1("acc_if_rvalid", if_rvalid[k], 1'b0);
            chk1("acc_d_rvalid", d_rvalid[k], 1'b0);
            tick;
        end
        #1;
        chk1("resp_if_rvalid", if_rvalid[k], w == 0);
        chk1("resp_d_rvalid", d_rvalid[k], w == 1);
        chk1("resp_mem_we", mem_we[k], 1'b0);
        chk1("resp_if_gnt", if_gnt[k], 1'b0);
        chk1("resp_d_gnt", d_gnt[k], 1'b0);
        if (w == 0) begin
            exp_if_rd[k] = ref_mem[k][idx];
            chk("if_rdata", if_rdata[k], exp_if_rd[k]);
            if (d_known[k]) chk("d_rdata_hold", d_rdata[k], exp_d_rd[k]);
        end else begin
            chk("if_rdata_hold", if_rdata[k], exp_if_rd[k]);
            if (ewe) begin
                ref_mem[k][idx] = ewd;
                d_known[k] = 1'b0;
                chk("mem_store", mem_at(k, idx), ewd);
            end else begin
                exp_d_rd[k] = ref_mem[k][idx];
                d_known[k] = 1'b1;
                chk("d_rdata", d_rdata[k], exp_d_rd[k]);
            end
        end
        tick;
    endtask

    initial begin
        int w;
        int eo;
        logic [31:0] a;
        n_chk = 0;
        n_fail = 0;
        if_req = '0; if_addr = '0; d_req = '0; d_we = '0; d_addr = '0; d_wdata = '0;
        reset = 1'b1;
        mem_init = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_val(i);
        model_reset;
        tick;
        tick;
        mem_init = 1'b0;
        reset = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        tick;

        // Fetch only, MEM_LAT=1
        if_addr[0] = 32'd5;
        if_req[0] = 1'b1;
        serve(0, 1'b0, 1'b0, w);
        chk("fetch_word", if_rdata[0], 32'h0081_0003);

        // Store then load at address 9
        d_we[0] = 1'b1; d_addr[0] = 32'd9; d_wdata[0] = 32'hDEAD_BEEF; d_req[0] = 1'b1;
        serve(0, 1'b0, 1'b0, w);
        d_we[0] = 1'b0; d_req[0] = 1'b1;
        serve(0, 1'b0, 1'b0, w);
        chk("load_back", d_rdata[0], 32'hDEAD_BEEF);

        // Tie with both requests held for four grants, then D drops and IF must win at once
        do_reset;
        if_addr[0] = 32'd3; d_addr[0] = 32'd4; d_we[0] = 1'b0;
        if_req[0] = 1'b1; d_req[0] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            serve(0, 1'b1, 1'b0, w);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            eo = (g % 2 == 0) ? 1 : 0;
`else
            eo = 1;
`endif
            chk("tie_order", 32'(w), 32'(eo));
        end
        d_req[0] = 1'b0;
        serve(0, 1'b0, 1'b0, w);
        chk("if_after_d_drop", 32'(w), 32'd0);

        // MEM_LAT=3 load; fetch raised during ACCESS is granted right after RESP
        d_we[1] = 1'b0; d_addr[1] = 32'd2; if_addr[1] = 32'd11; d_req[1] = 1'b1;
        serve(1, 1'b0, 1'b1, w);
        chk("lat3_owner", 32'(w), 32'd1);
        serve(1, 1'b0, 1'b0, w);
        chk("late_if_owner", 32'(w), 32'd0);

        // Reset during ACCESS of a store (cnt=1): store dropped, no response
        d_we[1] = 1'b1; d_addr[1] = 32'd7; d_wdata[1] = 32'h1234_5678; d_req[1] = 1'b1;
        #1;
        chk1("rst6_gnt", d_gnt[1], 1'b1);
        tick;
        d_req[1] = 1'b0;
        #1;
        chk1("rst6_we_a", mem_we[1], 1'b0);
        tick;
        reset = 1'b1;
        #1;
        chk1("rst6_we_b", mem_we[1], 1'b0);
        tick;
        reset = 1'b0;
        model_reset;
        #1;
        chk_zero(1);
        chk_zero(0);
        for (int c = 0; c < 4; c++) begin
            tick;
            chk1("rst6_no_rvalid", d_rvalid[1], 1'b0);
            chk1("rst6_no_we", mem_we[1], 1'b0);
        end
        chk("rst6_mem7", mem_at(1, 7), ref_mem[1][7]);

        // Randomized traffic on both latencies
        for (int k = 0; k < 2; k++) begin
            for (int e = 0; e < 25; e++) begin
                int pat;
                pat = $urandom_range(1, 3);
                a = $urandom(); a[5:3] = 3'b000; if_addr[k] = a;
                a = $urandom(); a[5:3] = 3'b000; d_addr[k] = a;
                d_we[k] = 1'($urandom_range(0, 1));
                d_wdata[k] = $urandom();
                if_req[k] = (pat & 1) != 0;
                d_req[k] = (pat & 2) != 0;
                serve(k, 1'b0, 1'b0, w);
                if (if_req[k] || d_req[k]) serve(k, 1'b0, 1'b0, w);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
